// File: rtl/fb_pkg.sv
// Frame buffer geometry, read-tag layout and address range helper shared by
// the frame buffer read arbiter and its tag pipe.
package fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = 17;

    localparam logic TAG_DISP    = 1'b0;
    localparam logic TAG_CV      = 1'b1;
    localparam int   TAG_ERR_BIT = 0;

    // err sits in bit TAG_ERR_BIT of the packed tag
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } tag_t;

    function automatic logic addr_in_range(input logic [FB_ADDR_W-1:0] addr);
        return addr < FB_ADDR_W'(FB_DEPTH);
    endfunction

endpackage

// File: rtl/fb_tag_pipe.sv
// Delays the issue tag by the RAM read latency so it lines up with mem_rdata.
module fb_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic CLK25,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // NOTE: every stage is reset, not just the valid bits; a reset must flush
    // all in-flight reads so late RAM data never produces a valid pulse.
    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the frame buffer read port between the display scanner (absolute
// priority) and the convolution engine (req/gnt, in-order pipelined returns).
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 1023
) (
    input  logic                 CLK25,
    input  logic                 reset,
    input  logic                 disp_en,
    input  logic [FB_ADDR_W-1:0] disp_addr,
    output logic                 disp_valid,
    output logic [DATA_W-1:0]    disp_data,
    input  logic                 cv_req,
    input  logic [FB_ADDR_W-1:0] cv_addr,
    output logic                 cv_gnt,
    output logic                 cv_rvalid,
    output logic [DATA_W-1:0]    cv_rdata,
    output logic                 mem_en,
    output logic [FB_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 addr_err,
    output logic                 cv_starve
);

    localparam int               CNT_W      = 10;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic                 issue_req;
    logic                 sel_port;
    logic [FB_ADDR_W-1:0] sel_addr;
    logic                 sel_err;
    logic                 denied;
    tag_t                 issue_tag;
    tag_t                 ret_tag;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_cnt_nxt;

    assign cv_gnt    = cv_req & ~disp_en;
    assign issue_req = disp_en | cv_req;
    assign sel_port  = disp_en ? TAG_DISP : TAG_CV;
    assign sel_addr  = disp_en ? disp_addr : cv_addr;
    assign sel_err   = ~addr_in_range(sel_addr);
    assign denied    = cv_req & disp_en;

    // Out-of-range reads are accepted but never reach the RAM; the tag
    // carries the error so the owning port still gets its return slot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            issue_tag <= '0;
        end else begin
            mem_en    <= issue_req & ~sel_err;
            if (issue_req && !sel_err) begin
                mem_addr <= sel_addr;
            end
            issue_tag <= '{valid: issue_req, port: sel_port, err: sel_err};
        end
    end

    fb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .CLK25   (CLK25),
        .reset   (reset),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cv_rvalid  <= 1'b0;
            cv_rdata   <= '0;
            addr_err   <= 1'b0;
        end else begin
            disp_valid <= ret_tag.valid && (ret_tag.port == TAG_DISP);
            cv_rvalid  <= ret_tag.valid && (ret_tag.port == TAG_CV);
            if (ret_tag.valid && ret_tag.port == TAG_DISP) begin
                disp_data <= ret_tag.err ? '0 : mem_rdata;
            end
            if (ret_tag.valid && ret_tag.port == TAG_CV) begin
                cv_rdata <= ret_tag.err ? '0 : mem_rdata;
            end
            if (ret_tag.valid && ret_tag.err) begin
                addr_err <= 1'b1;
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        wait_cnt_nxt = '0;
        if (denied) begin
            wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            cv_starve <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if (denied && wait_cnt_nxt == WAIT_LIMIT) begin
                cv_starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: display, convolution, contention,
// range errors, starvation and mid-flight reset against a 1-cycle RAM model.
module tb_fb_port_arbiter;

    logic        CLK25 = 1'b0;
    logic        reset = 1'b1;
    logic        disp_en = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        disp_valid;
    logic [11:0] disp_data;
    logic        cv_req = 1'b0;
    logic [16:0] cv_addr = '0;
    logic        cv_gnt;
    logic        cv_rvalid;
    logic [11:0] cv_rdata;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic [11:0] mem_rdata = '0;
    logic        addr_err;
    logic        cv_starve;

    int n_checks = 0;
    int n_err    = 0;

    fb_port_arbiter #(
        .DATA_W   (12),
        .RD_LAT   (1),
        .MAX_WAIT (8)
    ) dut (
        .CLK25      (CLK25),
        .reset      (reset),
        .disp_en    (disp_en),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .cv_req     (cv_req),
        .cv_addr    (cv_addr),
        .cv_gnt     (cv_gnt),
        .cv_rvalid  (cv_rvalid),
        .cv_rdata   (cv_rdata),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .addr_err   (addr_err),
        .cv_starve  (cv_starve)
    );

    always #20 CLK25 = ~CLK25;

    // Single-cycle synchronous RAM whose contents equal address[11:0]
    always @(posedge CLK25) begin
        if (mem_en) mem_rdata <= mem_addr[11:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK25);
        #1;
    endtask

    task automatic drive(input logic de, input logic [16:0] da,
                         input logic cr, input logic [16:0] ca);
        disp_en   = de;
        disp_addr = da;
        cv_req    = cr;
        cv_addr   = ca;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        next_cycle();
        next_cycle();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_cv_rvalid", cv_rvalid, 0);
        check("rst_cv_rdata", cv_rdata, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_cv_starve", cv_starve, 0);
        reset = 1'b0;

        // Display only: addresses 0..9, returns in cycles 3..12
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            drive(c < 10, 17'(c), 1'b0, '0);
            #1;
            check("disp_valid", disp_valid, (c >= 3 && c <= 12));
            if (c >= 3 && c <= 12) check("disp_data", disp_data, c - 3);
            check("disp_cv_rvalid", cv_rvalid, 0);
            check("disp_mem_en", mem_en, (c >= 1 && c <= 10));
            if (c >= 1 && c <= 10) check("disp_mem_addr", mem_addr, c - 1);
        end

        // Convolution single request at 1000
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            drive(1'b0, '0, c == 0, 17'd1000);
            #1;
            check("cv1_gnt", cv_gnt, (c == 0));
            check("cv1_rvalid", cv_rvalid, (c == 3));
            if (c == 3) check("cv1_rdata", cv_rdata, 1000);
            check("cv1_disp_valid", disp_valid, 0);
            check("cv1_disp_hold", disp_data, 9);
        end

        // Convolution back-to-back 1000..1003
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            drive(1'b0, '0, c < 4, 17'(1000 + c));
            #1;
            check("cv4_gnt", cv_gnt, (c < 4));
            check("cv4_rvalid", cv_rvalid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("cv4_rdata", cv_rdata, 1000 + c - 3);
        end

        // Contention: display 5 cycles, convolution 500 waits until cycle 6
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive(c < 5, 17'(10 + c), c <= 5, 17'd500);
            #1;
            if (c <= 5) check("cont_gnt", cv_gnt, (c == 5));
            check("cont_disp_valid", disp_valid, (c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) check("cont_disp_data", disp_data, c + 7);
            check("cont_cv_rvalid", cv_rvalid, (c == 8));
            if (c == 8) check("cont_cv_rdata", cv_rdata, 500);
        end
        check("cont_starve", cv_starve, 0);

        // Range: 76800 (disp), 131071 (cv), 76799 (disp)
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            case (c)
                0:       drive(1'b1, 17'd76800, 1'b0, '0);
                1:       drive(1'b0, '0, 1'b1, 17'd131071);
                2:       drive(1'b1, 17'd76799, 1'b0, '0);
                default: drive(1'b0, '0, 1'b0, '0);
            endcase
            #1;
            if (c == 1) check("rng_gnt", cv_gnt, 1);
            check("rng_mem_en", mem_en, (c == 3));
            if (c == 1 || c == 2) check("rng_mem_addr_hold", mem_addr, 500);
            if (c == 3) check("rng_mem_addr", mem_addr, 76799);
            check("rng_disp_valid", disp_valid, (c == 3 || c == 5));
            if (c == 3) check("rng_disp_data_err", disp_data, 0);
            if (c == 5) check("rng_disp_data_ok", disp_data, 3071);
            check("rng_cv_rvalid", cv_rvalid, (c == 4));
            if (c == 4) check("rng_cv_rdata_err", cv_rdata, 0);
            check("rng_addr_err", addr_err, (c >= 3));
        end

        // Starvation: 7 denied cycles then a grant -> no flag
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            drive(c < 7, 17'd20, c < 8, 17'd600);
            #1;
            if (c < 8) check("st7_gnt", cv_gnt, (c == 7));
            check("st7_starve", cv_starve, 0);
        end

        // Starvation: 8 denied cycles -> flag after the 8th, sticky
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            drive(c < 8, 17'd20, c < 9, 17'd600);
            #1;
            if (c < 9) check("st8_gnt", cv_gnt, (c == 8));
            check("st8_starve", cv_starve, (c >= 8));
        end
        check("st8_addr_err_sticky", addr_err, 1);

        // Reset mid-flight: two requests, reset during cycle 2, new read at 7
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            reset = (c == 2);
            case (c)
                0:       drive(1'b1, 17'd30, 1'b0, '0);
                1:       drive(1'b0, '0, 1'b1, 17'd40);
                7:       drive(1'b0, '0, 1'b1, 17'd1234);
                default: drive(1'b0, '0, 1'b0, '0);
            endcase
            #1;
            if (c >= 2) begin
                check("rmf_disp_valid", disp_valid, 0);
                check("rmf_disp_data", disp_data, 0);
                check("rmf_cv_rvalid", cv_rvalid, (c == 10));
                check("rmf_cv_rdata", cv_rdata, (c >= 10) ? 1234 : 0);
                check("rmf_addr_err", addr_err, 0);
                check("rmf_starve", cv_starve, 0);
                check("rmf_mem_en", mem_en, (c == 8));
                check("rmf_mem_addr", mem_addr, (c >= 8) ? 1234 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
